// File: rtl/reg_file_mp_sb_if.sv
// Decode/writeback-facing bus of the multi-port register file with pending scoreboard.
// master = pipeline side (decode + writeback), slave = register file.
interface reg_file_mp_sb_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_READ = 2
);
  logic                         WRITE;
  logic [ADDR_W-1:0]            INADDRESS;
  logic [DATA_W-1:0]            IN;
  logic [NUM_READ*ADDR_W-1:0]   OUT_ADDR;
  logic [NUM_READ*DATA_W-1:0]   OUT;
  logic                         RSV;
  logic [ADDR_W-1:0]            RSV_ADDR;
  logic [NUM_READ-1:0]          PEND;
  logic                         READY;

  modport master (
    output WRITE, INADDRESS, IN, OUT_ADDR, RSV, RSV_ADDR,
    input  OUT, PEND, READY
  );

  modport slave (
    input  WRITE, INADDRESS, IN, OUT_ADDR, RSV, RSV_ADDR,
    output OUT, PEND, READY
  );
endinterface

// File: rtl/reg_file_mp_sb.sv
// NUM_READ-port register file (x0 = 0) with post-reset clear sequencer and pending scoreboard.
// Optional macro RF_WRITE_BYPASS_EN forwards a same-cycle writeback to matching read ports.
module reg_file_mp_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_READ = 2
) (
  input  logic           CLK,
  input  logic           RESET,
  reg_file_mp_sb_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t              state_q, state_d;
  idx_t                idx_q, idx_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]    busy_q;

  logic                clr_en, wr_en, rsv_en;
  idx_t                wr_idx, rsv_idx;
  logic [ADDR_W-1:0]   rd_addr;

  // x0 and out-of-range addresses never touch storage
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a != '0) && (32'(a) < DEPTH);
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr_en  = 1'b0;
    wr_en   = 1'b0;
    rsv_en  = 1'b0;
    wr_idx  = bus.INADDRESS[IDX_W-1:0];
    rsv_idx = bus.RSV_ADDR[IDX_W-1:0];
    unique case (state_q)
      S_CLEAR: begin
        clr_en = 1'b1;
        idx_d  = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = S_RUN;
      end
      S_RUN: begin
        wr_en  = bus.WRITE && addr_ok(bus.INADDRESS);
        rsv_en = bus.RSV && addr_ok(bus.RSV_ADDR);
      end
    endcase
    if (RESET) begin
      clr_en = 1'b0;
      wr_en  = 1'b0;
      rsv_en = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Reservation is applied after the commit so a same-address RSV keeps the bit set
  always_ff @(posedge CLK) begin
    if (RESET) begin
      busy_q <= '0;
    end else begin
      if (wr_en)  busy_q[wr_idx]  <= 1'b0;
      if (rsv_en) busy_q[rsv_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (clr_en)     mem_q[idx_q]  <= '0;
    else if (wr_en) mem_q[wr_idx] <= bus.IN;
  end

  assign bus.READY = (state_q == S_RUN);

  always_comb begin
    bus.OUT = '0;
    bus.PEND = '0;
    rd_addr = '0;
    for (int unsigned k = 0; k < NUM_READ; k++) begin
      rd_addr = bus.OUT_ADDR[k*ADDR_W +: ADDR_W];
      if ((state_q == S_RUN) && addr_ok(rd_addr)) begin
        bus.OUT[k*DATA_W +: DATA_W] = mem_q[rd_addr[IDX_W-1:0]];
        bus.PEND[k]                 = busy_q[rd_addr[IDX_W-1:0]];
`ifdef RF_WRITE_BYPASS_EN
        if (wr_en && (rd_addr == bus.INADDRESS)) begin
          bus.OUT[k*DATA_W +: DATA_W] = bus.IN;
          bus.PEND[k]                 = 1'b0;
        end
`else
`endif
      end
    end
  end
endmodule

// File: tb/tb_reg_file_mp_sb.sv
// Directed table-driven bench for reg_file_mp_sb (DEPTH=32, two read ports).
// Expectations for the same-cycle commit row follow RF_WRITE_BYPASS_EN.
module tb_reg_file_mp_sb;
  logic CLK = 1'b0;
  logic RESET;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 CLK = ~CLK;

  reg_file_mp_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2)) bus ();

  reg_file_mp_sb #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .NUM_READ(2)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct {
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rsv;
    logic [4:0]  ra;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  ep;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mk(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                              input logic rsv, input logic [4:0] ra,
                              input logic [4:0] a0, input logic [4:0] a1,
                              input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] ep);
    vec_t v;
    v.wr = wr; v.wa = wa; v.wd = wd; v.rsv = rsv; v.ra = ra;
    v.a0 = a0; v.a1 = a1; v.e0 = e0; v.e1 = e1; v.ep = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rsv, input logic [4:0] ra, input logic [4:0] a0, input logic [4:0] a1);
    bus.WRITE = wr; bus.INADDRESS = wa; bus.IN = wd;
    bus.RSV = rsv; bus.RSV_ADDR = ra; bus.OUT_ADDR = {a1, a0};
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Holds RESET low for 32 edges while hostile traffic is driven, checking outputs stay quiet
  task automatic clear_phase(input string tag);
    drive(1'b1, 5'd1, 32'h0000_0BAD, 1'b1, 5'd1, 5'd9, 5'd1);
    for (int i = 0; i < 32; i++) begin
      @(negedge CLK);
      chk($sformatf("%s ready c%0d", tag, i), 64'(bus.READY), 64'd0);
      chk($sformatf("%s out c%0d", tag, i), 64'(bus.OUT), 64'd0);
      chk($sformatf("%s pend c%0d", tag, i), 64'(bus.PEND), 64'd0);
      step();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge CLK);
    chk($sformatf("%s ready after 32", tag), 64'(bus.READY), 64'd1);
  endtask

  initial begin
    vt[0]  = mk(0, 0, 32'h0,         0, 0, 5, 0, 32'h0,    32'h0,    2'b00);
    vt[1]  = mk(1, 2, 32'h5F,        0, 0, 5, 0, 32'h0,    32'h0,    2'b00);
    vt[2]  = mk(1, 0, 32'hDEADBEEF,  0, 0, 2, 0, 32'h5F,   32'h0,    2'b00);
    vt[3]  = mk(0, 0, 32'h0,         0, 0, 0, 2, 32'h0,    32'h5F,   2'b00);
    vt[4]  = mk(0, 0, 32'h0,         1, 7, 2, 7, 32'h5F,   32'h0,    2'b00);
    vt[5]  = mk(0, 0, 32'h0,         1, 0, 0, 7, 32'h0,    32'h0,    2'b10);
    vt[6]  = mk(1, 7, 32'h1234,      0, 0, 0, 2, 32'h0,    32'h5F,   2'b00);
    vt[7]  = mk(0, 0, 32'h0,         0, 0, 0, 7, 32'h0,    32'h1234, 2'b00);
    vt[8]  = mk(1, 9, 32'hAA,        1, 9, 7, 2, 32'h1234, 32'h5F,   2'b00);
    vt[9]  = mk(0, 0, 32'h0,         0, 0, 9, 9, 32'hAA,   32'hAA,   2'b11);
    vt[10] = mk(0, 0, 32'h0,         1, 3, 3, 0, 32'h0,    32'h0,    2'b00);
`ifdef RF_WRITE_BYPASS_EN
    vt[11] = mk(1, 3, 32'h77,        0, 0, 3, 3, 32'h77,   32'h77,   2'b00);
`else
    vt[11] = mk(1, 3, 32'h77,        0, 0, 3, 3, 32'h0,    32'h0,    2'b11);
`endif
    vt[12] = mk(0, 0, 32'h0,         0, 0, 3, 9, 32'h77,   32'hAA,   2'b10);
    vt[13] = mk(1, 1, 32'h11,        1, 4, 2, 4, 32'h5F,   32'h0,    2'b00);
    vt[14] = mk(0, 0, 32'h0,         0, 0, 1, 4, 32'h11,   32'h0,    2'b10);
    vt[15] = mk(1, 2, 32'h22,        0, 0, 1, 3, 32'h11,   32'h77,   2'b00);
    vt[16] = mk(1, 4, 32'h44,        0, 0, 2, 3, 32'h22,   32'h77,   2'b00);
    vt[17] = mk(0, 0, 32'h0,         0, 0, 4, 9, 32'h44,   32'hAA,   2'b10);

    RESET = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd2);
    repeat (3) step();
    @(negedge CLK);
    chk("reset ready", 64'(bus.READY), 64'd0);
    chk("reset out", 64'(bus.OUT), 64'd0);
    chk("reset pend", 64'(bus.PEND), 64'd0);
    step();
    RESET = 1'b0;
    clear_phase("init");

    step();
    for (int i = 0; i < 18; i++) begin
      drive(vt[i].wr, vt[i].wa, vt[i].wd, vt[i].rsv, vt[i].ra, vt[i].a0, vt[i].a1);
      @(negedge CLK);
      chk($sformatf("vec%0d out0", i), 64'(bus.OUT[31:0]), 64'(vt[i].e0));
      chk($sformatf("vec%0d out1", i), 64'(bus.OUT[63:32]), 64'(vt[i].e1));
      chk($sformatf("vec%0d pend", i), 64'(bus.PEND), 64'(vt[i].ep));
      chk($sformatf("vec%0d ready", i), 64'(bus.READY), 64'd1);
      step();
    end

    // Reset mid-operation: x1..x4 and busy x9 must all be wiped
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd1, 5'd9);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    clear_phase("mid");
    step();
    for (int p = 0; p < 3; p++) begin
      logic [4:0] a0, a1;
      a0 = (p == 0) ? 5'd1 : (p == 1) ? 5'd3 : 5'd9;
      a1 = (p == 0) ? 5'd2 : (p == 1) ? 5'd4 : 5'd1;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, a0, a1);
      @(negedge CLK);
      chk($sformatf("post-reset out p%0d", p), 64'(bus.OUT), 64'd0);
      chk($sformatf("post-reset pend p%0d", p), 64'(bus.PEND), 64'd0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
